// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: register map,
// control/status bit positions, guard length and the hex segment table.
package seg7_pkg;

  localparam logic [2:0] ADDR_DIGITS = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_MASKS  = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;

  localparam int CTRL_EN_BIT      = 0;
  localparam int MASK_BLINK_LSB   = 0;
  localparam int MASK_BLANK_LSB   = 8;
  localparam int STATUS_PHASE_BIT = 8;

  // Dead time at the start of each slot when SEG7_GUARD_EN is built in
  localparam int GUARD_CYCLES = 16;

  localparam logic [6:0] SEG_OFF_N = 7'h7F;

  // Active-high gfedcba patterns, indexed by hex code
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic        en;
    logic [2:0]  addr;
    logic [31:0] data;
  } seg7_wr_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex code to active-high seven-segment pattern (bit0=a .. bit6=g).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb seg = HEX_SEG[code];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Avalon-MM seven-segment scan controller: register file, scan/blink timing
// and registered digit drive. Optional slot dead time via SEG7_GUARD_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [6:0]            seg_n,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_tick
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  seg7_wr_t bus_wr;
  logic     unused_wdata;

  logic [DW-1:0]         digits_q;
  logic                  enable_q;
  logic [NUM_DIGITS-1:0] blink_q;
  logic [NUM_DIGITS-1:0] blank_q;

  logic [PW-1:0] presc_q;
  logic [2:0]    idx_q;
  logic [FW-1:0] frame_q;
  logic          phase_q;

  logic presc_wrap, idx_wrap, frame_wrap, in_guard;

  logic [NUM_DIGITS-1:0][6:0] pat;
  logic [NUM_DIGITS-1:0]      den_d;
  logic [6:0]                 cur_pat, seg_d;
  logic                       cur_blink, cur_blank;

  assign bus_wr       = '{en: chipselect && !write_n, addr: address, data: writedata};
  assign unused_wdata = ^bus_wr.data;

  // Register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits_q <= '0;
      enable_q <= 1'b0;
      blink_q  <= '0;
      blank_q  <= '0;
    end else if (bus_wr.en) begin
      case (bus_wr.addr)
        ADDR_DIGITS: digits_q <= bus_wr.data[DW-1:0];
        ADDR_CTRL:   enable_q <= bus_wr.data[CTRL_EN_BIT];
        ADDR_MASKS: begin
          blink_q <= bus_wr.data[MASK_BLINK_LSB +: NUM_DIGITS];
          blank_q <= bus_wr.data[MASK_BLANK_LSB +: NUM_DIGITS];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DIGITS: readdata[DW-1:0] = digits_q;
      ADDR_CTRL:   readdata[CTRL_EN_BIT] = enable_q;
      ADDR_MASKS: begin
        readdata[MASK_BLINK_LSB +: NUM_DIGITS] = blink_q;
        readdata[MASK_BLANK_LSB +: NUM_DIGITS] = blank_q;
      end
      ADDR_STATUS: begin
        readdata[2:0]              = idx_q;
        readdata[STATUS_PHASE_BIT] = phase_q;
      end
      default: ;
    endcase
  end

  assign presc_wrap = (presc_q == PW'(SCAN_DIV - 1));
  assign idx_wrap   = presc_wrap && (idx_q == 3'(NUM_DIGITS - 1));
  assign frame_wrap = idx_wrap && (frame_q == FW'(BLINK_FRAMES - 1));

  // Scan timing; held cleared whenever the block is disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      phase_q <= 1'b0;
    end else if (!enable_q) begin
      presc_q <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      phase_q <= 1'b0;
    end else begin
      presc_q <= presc_wrap ? '0 : presc_q + PW'(1);
      if (presc_wrap) idx_q   <= idx_wrap ? '0 : idx_q + 3'd1;
      if (idx_wrap)   frame_q <= frame_wrap ? '0 : frame_q + FW'(1);
      if (frame_wrap) phase_q <= ~phase_q;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_hex_decode u_dec (
      .code (digits_q[4*g +: 4]),
      .seg  (pat[g])
    );
  end

  always_comb begin
    den_d     = '0;
    cur_pat   = '0;
    cur_blink = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        den_d[i]  = 1'b1;
        cur_pat   = pat[i];
        cur_blink = blink_q[i];
        cur_blank = blank_q[i];
      end
    end
    seg_d = (cur_blank || (cur_blink && phase_q)) ? 7'h00 : cur_pat;
  end

`ifdef SEG7_GUARD_EN
  assign in_guard = (presc_q < PW'(GUARD_CYCLES));
`else
  assign in_guard = 1'b0;
`endif

  // Blanked digits keep dig_en so the per-digit duty cycle stays constant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_n      <= SEG_OFF_N;
      dig_en     <= '0;
      frame_tick <= 1'b0;
    end else if (!enable_q) begin
      seg_n      <= SEG_OFF_N;
      dig_en     <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= idx_wrap;
      if (in_guard) begin
        seg_n  <= SEG_OFF_N;
        dig_en <= '0;
      end else begin
        seg_n  <= ~seg_d;
        dig_en <= den_d;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: expected {dig_en, seg_n} changes are
// queued by the stimulus and popped by a monitor whenever the outputs change.
module tb_seg7_scan_ctrl;
  import seg7_pkg::*;

  localparam int ND = 6;
  localparam int SD = 20;
  localparam int BF = 2;
`ifdef SEG7_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // Active-low patterns for digits 0..5 after writing 0x123456
  localparam logic [6:0] SEG_N_TBL [6] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [6:0]    seg_n;
  logic [ND-1:0] dig_en;
  logic          frame_tick;

  int checks = 0;
  int errors = 0;
  int pos    = 0;

  logic [12:0] exp_q [$];
  logic [12:0] last_push = {6'h00, 7'h7F};
  logic [12:0] prev_obs  = {6'h00, 7'h7F};
  logic [12:0] obs, e;
  logic [6:0]  sv;
  bit          mon_on = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .seg_n      (seg_n),
    .dig_en     (dig_en),
    .frame_tick (frame_tick)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] exp_den(input logic [5:0] den, input int k);
    return (GUARD && (((k - 1) % SD) < 16)) ? 6'h00 : den;
  endfunction

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
    pos += n;
  endtask

  task automatic goto_k(input int k);
    if (k > pos) adv(k - pos);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
    pos++;
  endtask

  task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(name, readdata, exp);
  endtask

  task automatic push_exp(input logic [5:0] den, input logic [6:0] seg);
    if ({den, seg} != last_push) begin
      exp_q.push_back({den, seg});
      last_push = {den, seg};
    end
  endtask

  task automatic push_slot(input int d, input logic [6:0] seg);
    if (GUARD) push_exp(6'h00, 7'h7F);
    push_exp(6'(1 << d), seg);
  endtask

  // Monitor: every change of the scan outputs consumes one expectation
  initial begin
    forever begin
      @(negedge clk);
      obs = {dig_en, seg_n};
      if (mon_on && obs !== prev_obs) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scan_out: unexpected output %0h (t=%0t)", obs, $time);
        end else begin
          e = exp_q.pop_front();
          chk("scan_out", 32'(obs), 32'(e));
        end
      end
      prev_obs = obs;
    end
  end

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg_n", 32'(seg_n), 32'h7F);
    chk("rst_dig_en", 32'(dig_en), 32'h0);
    chk("rst_frame_tick", 32'(frame_tick), 32'h0);
    reset_n = 1'b1;
    rd("rst_digits", ADDR_DIGITS, 32'h0);
    rd("rst_ctrl", ADDR_CTRL, 32'h0);
    rd("rst_masks", ADDR_MASKS, 32'h0);
    rd("rst_status", ADDR_STATUS, 32'h0);
    mon_on = 1'b1;

    // Main scan with blink on digit 0, blank+blink from frame 6, new codes from frame 9
    wr(ADDR_DIGITS, 32'h0012_3456);
    wr(ADDR_MASKS, 32'h0000_0001);
    rd("digits_rb", ADDR_DIGITS, 32'h0012_3456);
    rd("masks_rb", ADDR_MASKS, 32'h1);
    for (int f = 0; f < 9; f++) begin
      for (int d = 0; d < ND; d++) begin
        sv = SEG_N_TBL[d];
        if (d == 0 && (f >= 6 || ((f / 2) % 2) == 1)) sv = 7'h7F;
        if (f == 8 && d == 5) begin
          push_slot(5, GUARD ? 7'h40 : 7'h79);
          push_exp(6'h20, 7'h40);
        end else begin
          push_slot(d, sv);
        end
      end
    end
    push_slot(0, 7'h0E);
    push_slot(1, 7'h40);
    push_slot(2, 7'h40);
    push_slot(3, 7'h40);
    push_exp(6'h00, 7'h7F);

    wr(ADDR_CTRL, 32'h1);
    pos = 0;
    goto_k(119); chk("frame_tick_119", 32'(frame_tick), 32'h0);
    goto_k(120); chk("frame_tick_120", 32'(frame_tick), 32'h1);
    goto_k(121); chk("frame_tick_121", 32'(frame_tick), 32'h0);
    goto_k(170); rd("status_170", ADDR_STATUS, 32'h002);
    goto_k(240); chk("frame_tick_240", 32'(frame_tick), 32'h1);
    goto_k(250); rd("status_250", ADDR_STATUS, 32'h100);
    goto_k(310); rd("status_310", ADDR_STATUS, 32'h103);
    goto_k(705); wr(ADDR_MASKS, 32'h0000_0101);
    rd("masks_0101", ADDR_MASKS, 32'h0101);
    goto_k(1062);
    wr(ADDR_DIGITS, 32'h0000_000F);
    wr(ADDR_MASKS, 32'h0);
    goto_k(1157);
    wr(ADDR_CTRL, 32'h0);
    chk("dis_edge1_dig_en", 32'(dig_en), 32'h08);
    rd("dis_edge1_status", ADDR_STATUS, 32'h003);
    adv(1);
    chk("dis_edge2_dig_en", 32'(dig_en), 32'h0);
    chk("dis_edge2_seg_n", 32'(seg_n), 32'h7F);
    rd("dis_edge2_status", ADDR_STATUS, 32'h0);

    // Field widths, read-only and unmapped addresses
    wr(ADDR_DIGITS, 32'hFFFF_FFFF);
    rd("digits_width", ADDR_DIGITS, 32'h00FF_FFFF);
    wr(ADDR_MASKS, 32'hFFFF_FFFF);
    rd("masks_width", ADDR_MASKS, 32'h3F3F);
    wr(ADDR_CTRL, 32'hFFFF_FFFE);
    rd("ctrl_width", ADDR_CTRL, 32'h0);
    wr(ADDR_STATUS, 32'hFFFF_FFFF);
    rd("status_ro", ADDR_STATUS, 32'h0);
    wr(3'd5, 32'hFFFF_FFFF);
    rd("addr5_read", 3'd5, 32'h0);
    rd("addr5_no_alias", ADDR_DIGITS, 32'h00FF_FFFF);
    wr(ADDR_DIGITS, 32'h0000_000F);
    wr(ADDR_MASKS, 32'h0);

    // Re-enable: digit 0 first, full slot, guard window when built in
    push_slot(0, 7'h0E);
    push_slot(1, 7'h40);
    push_slot(2, 7'h40);
    push_exp(6'h00, 7'h7F);
    wr(ADDR_CTRL, 32'h1);
    pos = 0;
    goto_k(1);  chk("ren_k1", 32'(dig_en), 32'(exp_den(6'h01, 1)));
    goto_k(16); chk("ren_k16", 32'(dig_en), 32'(exp_den(6'h01, 16)));
    goto_k(17); chk("ren_k17", 32'(dig_en), 32'h01);
    goto_k(20); chk("ren_k20", 32'(dig_en), 32'h01);
    chk("ren_k20_seg", 32'(seg_n), 32'h0E);
    goto_k(21); chk("ren_k21", 32'(dig_en), 32'(exp_den(6'h02, 21)));
    goto_k(37); chk("ren_k37", 32'(dig_en), 32'h02);
    goto_k(58);
    wr(ADDR_CTRL, 32'h0);
    adv(1);
    chk("dis2_dig_en", 32'(dig_en), 32'h0);

    // Asynchronous reset in the middle of a frame_tick cycle
    for (int d = 0; d < ND; d++) push_slot(d, (d == 0) ? 7'h0E : 7'h40);
    push_exp(6'h00, 7'h7F);
    wr(ADDR_CTRL, 32'h1);
    pos = 0;
    goto_k(120);
    chk("pre_rst_frame_tick", 32'(frame_tick), 32'h1);
    chk("pre_rst_dig_en", 32'(dig_en), 32'h20);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_seg_n", 32'(seg_n), 32'h7F);
    chk("async_rst_dig_en", 32'(dig_en), 32'h0);
    chk("async_rst_frame_tick", 32'(frame_tick), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    rd("post_rst_digits", ADDR_DIGITS, 32'h0);
    rd("post_rst_ctrl", ADDR_CTRL, 32'h0);
    rd("post_rst_masks", ADDR_MASKS, 32'h0);
    rd("post_rst_status", ADDR_STATUS, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
